// File: rtl/uart_mem_dump_pkg.sv
// Shared UART definitions: frame layout, baud divisor and dump FSM encoding.
package uart_mem_dump_pkg;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_SEND, ST_NEXT, ST_FIN
  } dump_state_e;

  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_mem_dump_if.sv
// Control handshake plus synchronous memory read port of the dump engine.
interface uart_mem_dump_if #(parameter int ADDR_W = 12);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;

  modport master (input  start, base_addr, word_count, mem_rd_data,
                  output busy, done, mem_rd_en, mem_rd_addr);
  modport slave  (output start, base_addr, word_count, mem_rd_data,
                  input  busy, done, mem_rd_en, mem_rd_addr);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; ready only while idle, start bit drives the cycle after accept.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int BIT_CYCLES = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx
);
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic                  active;
  logic [CNT_W-1:0]      bit_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  bit_end;

  assign bit_end  = (bit_cnt == CNT_W'(BIT_CYCLES - 1));
  assign tx_ready = !active;
  assign uart_tx  = active ? shreg[0] : STOP_BIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (!active) begin
      if (tx_valid) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        bit_idx <= '0;
        shreg   <= {STOP_BIT, tx_data, START_BIT};
      end
    end else if (bit_end) begin
      bit_cnt <= '0;
      // Dropping active after the stop bit's last clock frees the line for one idle cycle.
      if (bit_idx == 4'(FRAME_BITS - 1)) begin
        active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        shreg   <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
      end
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_mem_dump.sv
// Reads a block of 32-bit words and streams them MSB byte first over the UART.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD),
  parameter int ADDR_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  uart_mem_dump_if.master  bus,
  output logic             uart_tx
);
  dump_state_e       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic [7:0]        tx_data;
  logic              tx_valid, tx_ready;

  assign tx_data         = word[{byte_idx, 3'b000} +: 8];
  assign bus.busy        = (state != ST_IDLE) && (state != ST_FIN);
  assign bus.done        = (state == ST_FIN);
  assign bus.mem_rd_en   = (state == ST_RD_REQ);
  assign bus.mem_rd_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    case (state)
      ST_IDLE:    if (bus.start) state_nxt = (bus.word_count == '0) ? ST_FIN : ST_RD_REQ;
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = ST_SEND;
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && byte_idx == 2'd0) state_nxt = ST_NEXT;
      end
      // Next read waits for the last stop bit so reads never overlap a frame.
      ST_NEXT:    if (tx_ready) state_nxt = (remaining == (ADDR_W+1)'(1)) ? ST_FIN : ST_RD_REQ;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          addr      <= bus.base_addr;
          remaining <= bus.word_count;
        end
        ST_RD_WAIT: begin
          word     <= bus.mem_rd_data;
          byte_idx <= 2'd3;
        end
        ST_SEND: if (tx_ready && byte_idx != 2'd0) byte_idx <= byte_idx - 2'd1;
        ST_NEXT: if (tx_ready) begin
          remaining <= remaining - (ADDR_W+1)'(1);
          addr      <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_tx  (uart_tx)
  );
endmodule

// File: tb/tb_uart_mem_dump.sv
// Randomised bench: memory model, UART line decoder and queue-based reference of the dump stream.
module tb_uart_mem_dump;
  localparam int BC = 8;
  localparam int WORD_CYC = 40*BC + 7;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;
  int   n_chk, n_err;
  int   cyc = 0, done_cnt = 0, low_cnt = 0;

  logic [31:0] mem [4096];
  logic [7:0]  rx_q[$];
  bit          ok_q[$];
  logic [11:0] rd_q[$];
  int          rd_cyc[$];

  uart_mem_dump_if #(.ADDR_W(12)) bus ();

  uart_mem_dump #(.CLK_FREQ(50000000), .BAUD(9600), .BIT_CYCLES(BC), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    else               bus.mem_rd_data <= $urandom;
  end

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (uart_tx == 1'b0) low_cnt++;
    if (bus.mem_rd_en) begin
      rd_q.push_back(bus.mem_rd_addr);
      rd_cyc.push_back(cyc);
    end
  end

  // Line decoder: each of the 10 bits must hold one value for exactly BC samples.
  initial begin
    logic [9:0] fr;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && uart_tx === 1'b0) begin
        ok = 1;
        for (int k = 0; k < 10; k++)
          for (int j = 0; j < BC; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (j == 0) fr[k] = uart_tx;
            else if (uart_tx !== fr[k]) ok = 0;
          end
        if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 0;
        rx_q.push_back(fr[8:1]);
        ok_q.push_back(ok);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input logic [11:0] base, input logic [12:0] cnt, input bit poke);
    logic [7:0]  eb[$];
    logic [11:0] ea[$];
    logic [11:0] a;
    logic [31:0] w;
    int d0, n, lim, low0, m;
    bit busy_ok;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 12'(i);
      ea.push_back(a);
      w = mem[a];
      for (int b = 3; b >= 0; b--) eb.push_back(w[8*b +: 8]);
    end
    rx_q.delete(); ok_q.delete(); rd_q.delete(); rd_cyc.delete();
    d0 = done_cnt; low0 = low_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_addr = 12'($urandom); bus.word_count = 13'($urandom);
    busy_ok = 1; n = 0; lim = int'(cnt) * WORD_CYC + 20;
    while (1) begin
      @(negedge clk); n++;
      if (poke) bus.start = (n == 50);
      if (bus.done || n > lim) break;
      if (!bus.busy) busy_ok = 0;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 1);
    chk("done_latency", n, 1 + int'(cnt) * WORD_CYC);
    chk("busy_at_done", 32'(bus.busy), 0);
    if (cnt != 0) chk("busy_held", 32'(busy_ok), 1);
    else          chk("zero_tx_idle", low_cnt - low0, 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("n_reads", rd_q.size(), ea.size());
    m = (rd_q.size() < ea.size()) ? rd_q.size() : ea.size();
    for (int i = 0; i < m; i++) chk($sformatf("rd_addr[%0d]", i), 32'(rd_q[i]), 32'(ea[i]));
    for (int i = 1; i < rd_cyc.size(); i++)
      chk($sformatf("rd_gap[%0d]", i), rd_cyc[i] - rd_cyc[i-1], WORD_CYC);
    chk("n_bytes", rx_q.size(), eb.size());
    m = (rx_q.size() < eb.size()) ? rx_q.size() : eb.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("byte[%0d]", i), 32'(rx_q[i]), 32'(eb[i]));
      chk($sformatf("frame[%0d]", i), 32'(ok_q[i]), 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h00100093; mem[1] = 32'h00200113;
    mem[2] = 32'h001080B3; mem[3] = 32'hFE208EE3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst_rd_addr", 32'(bus.mem_rd_addr), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);

    run_dump(12'd0, 13'd1, 0);
    run_dump(12'd0, 13'd4, 0);
    run_dump(12'd0, 13'd0, 0);
    run_dump(12'd4095, 13'd2, 1);

    // Reset during data bit 3 of the second byte of a two-word dump.
    rx_q.delete(); rd_q.delete(); rd_cyc.delete();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 12'($urandom); bus.word_count = 13'd2;
    @(posedge clk); #1; bus.start = 1'b0;
    w = 0;
    while (rx_q.size() < 1 && w < 20*BC) begin @(posedge clk); #1; w++; end
    chk("abort_first_byte", 32'(rx_q.size() >= 1), 1);
    w = 0;
    while (uart_tx !== 1'b0 && w < 4*BC) begin @(posedge clk); #1; w++; end
    chk("abort_second_start", 32'(uart_tx), 0);
    repeat (4*BC + BC/2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_uart_tx", 32'(uart_tx), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_rd_en", 32'(bus.mem_rd_en), 0);
    w = done_cnt;
    repeat (12*BC) @(posedge clk);
    chk("abort_no_done", done_cnt - w, 0);
    chk("abort_reads", rd_q.size(), 1);
    run_dump(12'($urandom), 13'd1, 0);

    for (int t = 0; t < 3; t++) run_dump(12'($urandom), 13'($urandom_range(1, 3)), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
